// File: rtl/expansion_shiftreg_target_pkg.sv
// Shared definitions for the expansion shift-register target: default frame
// width and the edge classification used by the link-line synchronisers.
package expansion_shiftreg_target_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

    // Classify the transition between the previous and current sampled level.
    function automatic edge_t classify_edge(input logic prev, input logic curr);
        edge_t kind;
        kind = EDGE_NONE;
        if (!prev && curr) begin
            kind = EDGE_RISE;
        end else if (prev && !curr) begin
            kind = EDGE_FALL;
        end
        return kind;
    endfunction

endpackage

// File: rtl/expansion_shiftreg_target_sync_edge_detect.sv
// Synchroniser for one asynchronous link line: SYNC_STAGES flops bring the pin
// into the clk domain, one history flop behind them gives edge detection.
// The edge is reported combinationally from the last sync flop and the history
// flop, so the consuming register acts SYNC_STAGES+1 cycles after the pin moves.
module sync_edge_detect
    import expansion_shiftreg_target_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  pin,
    output logic  level,
    output edge_t edge_kind
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   hist_p;

    // Synchroniser chain followed by the edge-history flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            hist_p <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], pin};
            hist_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign level     = sync_p[SYNC_STAGES-1];
    assign edge_kind = classify_edge(hist_p, level);

endmodule

// File: rtl/expansion_shiftreg_target.sv
// Target end of the expansion shift-register link. Emulates an output-latch
// and input-load shift-register chain: bits shifted in MSB-first are latched to
// data_out on a load strobe, and the same strobe snapshots data_in which is
// then returned MSB-first on SHIFT_DOUT. A watchdog forces data_out to
// SAFE_VALUE if no load arrives for TIMEOUT cycles.
module expansion_shiftreg_target
    import expansion_shiftreg_target_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter int               TIMEOUT     = 50000000,
    parameter logic [WIDTH-1:0] SAFE_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SHIFT_CLK,
    input  logic             SHIFT_LOAD,
    input  logic             SHIFT_DIN,
    output logic             SHIFT_DOUT,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_valid,
    output logic             frame_error,
    output logic             timeout
);

    // bit_cnt must hold WIDTH+1 so an over-long frame stays distinguishable
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    edge_t clk_edge;
    edge_t load_edge;
    edge_t din_edge_unused;
    logic  clk_level_unused;
    logic  load_level;
    logic  din_sync;
    logic  clk_rise;
    logic  load_rise;

    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_sr;
    logic [CNT_W-1:0] bit_cnt;
    logic [WD_W-1:0]  wdog;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (SHIFT_CLK),
        .level     (clk_level_unused),
        .edge_kind (clk_edge)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (SHIFT_LOAD),
        .level     (load_level),
        .edge_kind (load_edge)
    );

    // Data shares the same depth as SHIFT_CLK so it is aligned with the clk edge
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (SHIFT_DIN),
        .level     (din_sync),
        .edge_kind (din_edge_unused)
    );

    assign clk_rise  = (clk_edge == EDGE_RISE);
    assign load_rise = (load_edge == EDGE_RISE);

    // Frame capture, shift path, watchdog and status flags; load has priority
    // over a coincident shift edge, which is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= SAFE_VALUE;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            timeout     <= 1'b0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            wdog        <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (load_rise) begin
                if (bit_cnt == CNT_FULL) begin
                    data_out    <= rx_sr;
                    frame_valid <= 1'b1;
                    timeout     <= 1'b0;
                end else begin
                    frame_error <= 1'b1;
                end
                tx_sr   <= data_in;
                bit_cnt <= '0;
                wdog    <= '0;
            end else begin
                if (clk_rise && !load_level) begin
                    rx_sr <= {rx_sr[WIDTH-2:0], din_sync};
                    tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (WD_EN) begin
                    if (wdog != WD_LIMIT) begin
                        wdog <= wdog + 1'b1;
                    end
                    if (wdog == WD_LAST) begin
                        data_out <= SAFE_VALUE;
                        timeout  <= 1'b1;
                    end
                end
            end
        end
    end

    // Registered serial return: MSB of the transmit shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SHIFT_DOUT <= 1'b0;
        end else begin
            SHIFT_DOUT <= tx_sr[WIDTH-1];
        end
    end

endmodule
